fft_window_peak: RTL and testbench



---
 rtl/fft_window_pkg.sv | 21 ++
 rtl/hann_rom.sv | 35 +++
 rtl/fft_window_peak.sv | 172 +++++++++++++++++
 tb/tb_fft_window_peak.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_window_pkg.sv
// fft_window_pkg
//   Shared sizing constants and the complex beat layout used by the audio
//   FFT front/back end (fft_window_peak) and its Hann coefficient ROM.
//   No ports; imported by hann_rom and fft_window_peak.
package fft_window_pkg;

  localparam int N            = 4096;
  localparam int SAMPLE_WIDTH = 8;
  localparam int COEF_WIDTH   = 8;
  localparam int BIN_WIDTH    = $clog2(N);
  localparam int MAG_WIDTH    = 17;

  localparam real PI = 3.14159265358979323846;

  // One complex FFT beat as it travels on the 16-bit AXIS buses.
  typedef struct packed {
    logic signed [7:0] im;
    logic signed [7:0] re;
  } cplx_t;

endpackage

// File: rtl/hann_rom.sv
// hann_rom
//   Synchronous-read periodic Hann window coefficient ROM,
//   coef[n] = round((2^WIDTH - 1) * 0.5 * (1 - cos(2*pi*n/DEPTH))).
//   The table is evaluated at elaboration with the same formula used to
//   produce hann_N.mem offline, so the two are interchangeable.
// Ports:
//   clk  : clock
//   addr : coefficient index n
//   coef : coefficient for the address presented on the previous edge
module hann_rom
  import fft_window_pkg::*;
#(
  parameter int DEPTH = N,
  parameter int WIDTH = COEF_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] coef
);

  logic [WIDTH-1:0] table_w [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_coef
    localparam real AMP = 0.5 * ((2.0 ** WIDTH) - 1.0);
    localparam real VAL = AMP * (1.0 - $cos(2.0 * PI * i / DEPTH));
    localparam int unsigned C = $rtoi(VAL + 0.5);
    assign table_w[i] = C[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    coef <= table_w[addr];
  end

endmodule

// File: rtl/fft_window_peak.sv
// fft_window_peak
//   Front end: windows each signed audio sample with a periodic Hann window
//   and offers it as a one-beat AXIS holding register to an external FFT.
//   Back end: scans the FFT output frame, tracks the strongest bin among
//   1..N/2-1 by re^2+im^2 and reports it once per frame.
// Ports:
//   clk_in, rst_in           : clock, asynchronous active-low reset
//   in_sample                : signed audio sample
//   audio_sample_valid       : one-cycle strobe qualifying in_sample
//   fft_in_data/valid/last   : AXIS beat to the FFT, {im = 0, re = windowed}
//   fft_ready                : AXIS ready from the FFT
//   fft_out_data/valid/last  : FFT output beats {im, re}
//   fft_out_ready            : always 1, the peak search never stalls
//   peak_out, peak_mag_out   : strongest bin of the last frame and its re^2+im^2
//   peak_valid_out           : one-cycle strobe when a new result is posted
//   overflow_out             : sticky, set when a windowed sample is dropped
module fft_window_peak #(
  parameter int SAMPLE_WIDTH = fft_window_pkg::SAMPLE_WIDTH,
  parameter int N            = fft_window_pkg::N,
  parameter int COEF_WIDTH   = fft_window_pkg::COEF_WIDTH,
  parameter int BIN_WIDTH    = $clog2(N)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic signed [SAMPLE_WIDTH-1:0]      in_sample,
  input  logic                                audio_sample_valid,
  output logic [15:0]                         fft_in_data,
  output logic                                fft_in_valid,
  output logic                                fft_in_last,
  input  logic                                fft_ready,
  input  logic [15:0]                         fft_out_data,
  input  logic                                fft_out_valid,
  input  logic                                fft_out_last,
  output logic                                fft_out_ready,
  output logic [BIN_WIDTH-1:0]                peak_out,
  output logic [fft_window_pkg::MAG_WIDTH-1:0] peak_mag_out,
  output logic                                peak_valid_out,
  output logic                                overflow_out
);

  import fft_window_pkg::*;

  localparam logic [BIN_WIDTH-1:0] LAST_IDX = BIN_WIDTH'(N - 1);
  localparam logic [BIN_WIDTH-1:0] HALF_IDX = BIN_WIDTH'(N / 2);

  // Arithmetic shift of the full product keeps floor rounding for negative
  // samples; the coefficient is below 2^COEF_WIDTH so the top bits are spare.
  function automatic logic signed [SAMPLE_WIDTH-1:0] window_mul(
    input logic signed [SAMPLE_WIDTH-1:0] s,
    input logic        [COEF_WIDTH-1:0]   c
  );
    logic signed [SAMPLE_WIDTH+COEF_WIDTH:0] prod;
    prod = s * $signed({1'b0, c});
    return prod[COEF_WIDTH +: SAMPLE_WIDTH];
  endfunction

  function automatic logic [MAG_WIDTH-1:0] mag_sq(input cplx_t b);
    logic signed [MAG_WIDTH:0] acc;
    acc = $signed(b.re) * $signed(b.re) + $signed(b.im) * $signed(b.im);
    return acc[MAG_WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // Window path
  // ---------------------------------------------------------------------
  logic [BIN_WIDTH-1:0]           n_idx;
  logic signed [SAMPLE_WIDTH-1:0] sample_p0;
  logic [COEF_WIDTH-1:0]          coef_p0;
  logic                           vld_p0;
  logic signed [SAMPLE_WIDTH-1:0] win_p0;
  logic                           load_p1;
  logic                           drop_p1;

  // The ROM is addressed with the index of the next sample to be accepted.
  // Audio strobes are far apart relative to the 2-cycle path, so a sample
  // in flight never sees the index change underneath it.
  hann_rom #(
    .DEPTH (N),
    .WIDTH (COEF_WIDTH),
    .AW    (BIN_WIDTH)
  ) u_rom (
    .clk  (clk_in),
    .addr (n_idx),
    .coef (coef_p0)
  );

  always_ff @(posedge clk_in) begin
    if (audio_sample_valid) begin
      sample_p0 <= in_sample;
    end
  end

  // --- stage p0 -> p1: multiply and load the AXIS holding register ---
  assign win_p0  = window_mul(sample_p0, coef_p0);
  // The register can take a new beat when empty or when its beat leaves now.
  assign load_p1 = vld_p0 && (!fft_in_valid || fft_ready);
  assign drop_p1 = vld_p0 && !load_p1;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_p0       <= 1'b0;
      fft_in_valid <= 1'b0;
      fft_in_data  <= '0;
      fft_in_last  <= 1'b0;
      n_idx        <= '0;
      overflow_out <= 1'b0;
    end else begin
      vld_p0 <= audio_sample_valid;
      if (load_p1) begin
        fft_in_valid <= 1'b1;
        fft_in_data  <= {{(16 - SAMPLE_WIDTH){1'b0}}, win_p0};
        fft_in_last  <= (n_idx == LAST_IDX);
        n_idx        <= n_idx + 1'b1;
      end else if (fft_in_valid && fft_ready) begin
        fft_in_valid <= 1'b0;
      end
      if (drop_p1) begin
        overflow_out <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Peak search
  // ---------------------------------------------------------------------
  cplx_t                beat;
  logic [MAG_WIDTH-1:0] mag;
  logic [BIN_WIDTH-1:0] k_idx;
  logic [MAG_WIDTH-1:0] max_mag;
  logic [BIN_WIDTH-1:0] max_idx;
  logic                 cand;
  logic                 better;

  assign fft_out_ready = 1'b1;
  assign beat          = cplx_t'(fft_out_data);
  assign mag           = mag_sq(beat);
  // DC and the mirrored upper half carry no new information for real input.
  assign cand          = (k_idx != '0) && (k_idx < HALF_IDX);
  // Strictly greater, so the lowest bin keeps a tie.
  assign better        = cand && (mag > max_mag);

  // --- stage p0 -> p1: running max update and per-frame result ---
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      k_idx          <= '0;
      max_mag        <= '0;
      max_idx        <= '0;
      peak_out       <= '0;
      peak_mag_out   <= '0;
      peak_valid_out <= 1'b0;
    end else begin
      peak_valid_out <= 1'b0;
      if (fft_out_valid) begin
        if (fft_out_last) begin
          peak_out       <= better ? k_idx : max_idx;
          peak_mag_out   <= better ? mag : max_mag;
          peak_valid_out <= 1'b1;
          k_idx          <= '0;
          max_mag        <= '0;
          max_idx        <= '0;
        end else begin
          k_idx <= k_idx + 1'b1;
          if (better) begin
            max_idx <= k_idx;
            max_mag <= mag;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_window_peak.sv
module tb_fft_window_peak;

  localparam int N = 4096;

  logic               clk;
  logic               rst_in;
  logic signed [7:0]  in_sample;
  logic               audio_sample_valid;
  logic [15:0]        fft_in_data;
  logic               fft_in_valid;
  logic               fft_in_last;
  logic               fft_ready;
  logic [15:0]        fft_out_data;
  logic               fft_out_valid;
  logic               fft_out_last;
  logic               fft_out_ready;
  logic [11:0]        peak_out;
  logic [16:0]        peak_mag_out;
  logic               peak_valid_out;
  logic               overflow_out;

  int total = 0;
  int bad   = 0;

  logic [15:0] frame_mem [N];

  fft_window_peak dut (
    .clk_in             (clk),
    .rst_in             (rst_in),
    .in_sample          (in_sample),
    .audio_sample_valid (audio_sample_valid),
    .fft_in_data        (fft_in_data),
    .fft_in_valid       (fft_in_valid),
    .fft_in_last        (fft_in_last),
    .fft_ready          (fft_ready),
    .fft_out_data       (fft_out_data),
    .fft_out_valid      (fft_out_valid),
    .fft_out_last       (fft_out_last),
    .fft_out_ready      (fft_out_ready),
    .peak_out           (peak_out),
    .peak_mag_out       (peak_mag_out),
    .peak_valid_out     (peak_valid_out),
    .overflow_out       (overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Strobe one sample; report valid one edge later and the beat two edges later.
  task automatic send_sample(input logic signed [7:0] s, output logic v1,
                             output logic v2, output logic [15:0] d, output logic l);
    @(posedge clk); #1;
    in_sample = s;
    audio_sample_valid = 1'b1;
    @(posedge clk); #1;
    audio_sample_valid = 1'b0;
    v1 = fft_in_valid;
    @(posedge clk); #1;
    v2 = fft_in_valid;
    d  = fft_in_data;
    l  = fft_in_last;
  endtask

  task automatic clear_frame();
    for (int b = 0; b < N; b++) frame_mem[b] = 16'h0000;
  endtask

  task automatic play_frame(input int nbeats, input bit with_last);
    for (int b = 0; b < nbeats; b++) begin
      @(posedge clk); #1;
      fft_out_data  = frame_mem[b];
      fft_out_valid = 1'b1;
      fft_out_last  = with_last && (b == nbeats - 1);
      if (with_last && (b == nbeats - 1)) begin
        total++;
        if (peak_valid_out !== 1'b0) begin
          bad++;
          $display("FAIL frame_no_early_valid got=%0b want=0", peak_valid_out);
        end
      end
    end
    @(posedge clk); #1;
    fft_out_valid = 1'b0;
    fft_out_last  = 1'b0;
    fft_out_data  = 16'h0000;
  endtask

  task automatic check_peak(input string name, input logic [11:0] idx, input logic [16:0] m);
    total++;
    if (peak_valid_out !== 1'b1) begin
      bad++;
      $display("FAIL %s_valid got=%0b want=1", name, peak_valid_out);
    end
    total++;
    if (peak_out !== idx) begin
      bad++;
      $display("FAIL %s_index got=%0d want=%0d", name, peak_out, idx);
    end
    total++;
    if (peak_mag_out !== m) begin
      bad++;
      $display("FAIL %s_mag got=%0d want=%0d", name, peak_mag_out, m);
    end
    @(posedge clk); #1;
    total++;
    if (peak_valid_out !== 1'b0 || peak_out !== idx || peak_mag_out !== m) begin
      bad++;
      $display("FAIL %s_hold got=%0b/%0d/%0d want=0/%0d/%0d", name,
               peak_valid_out, peak_out, peak_mag_out, idx, m);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    in_sample = '0;
    audio_sample_valid = 1'b0;
    fft_ready = 1'b1;
    fft_out_data = 16'h0000;
    fft_out_valid = 1'b0;
    fft_out_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({fft_in_valid, fft_in_last, fft_in_data} !== 18'd0) begin
      bad++;
      $display("FAIL reset_fft_in got=%0h want=0", {fft_in_valid, fft_in_last, fft_in_data});
    end
    total++;
    if (fft_out_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_out_ready got=%0b want=1", fft_out_ready);
    end
    total++;
    if ({peak_valid_out, peak_out, peak_mag_out} !== 30'd0) begin
      bad++;
      $display("FAIL reset_peak got=%0h want=0", {peak_valid_out, peak_out, peak_mag_out});
    end
    total++;
    if (overflow_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_overflow got=%0b want=0", overflow_out);
    end
    rst_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (fft_in_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_valid got=%0b want=0", fft_in_valid);
    end
  endtask

  task automatic test_window();
    logic v1, v2, l;
    logic [15:0] d;
    fft_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i < 3) repeat (48) @(posedge clk);
      send_sample(8'sd127, v1, v2, d, l);
      total++;
      if (v1 !== 1'b0) begin
        bad++;
        $display("FAIL win_latency_early i=%0d got=%0b want=0", i, v1);
      end
      total++;
      if (v2 !== 1'b1) begin
        bad++;
        $display("FAIL win_latency i=%0d got=%0b want=1", i, v2);
      end
      total++;
      if (l !== (i == N - 1)) begin
        bad++;
        $display("FAIL win_last i=%0d got=%0b want=%0b", i, l, (i == N - 1));
      end
      if (i == 0 || i == N / 4 || i == N / 2) begin
        total++;
        if (d !== ((i == 0) ? 16'h0000 : (i == N / 4) ? 16'h003F : 16'h007E)) begin
          bad++;
          $display("FAIL win_data i=%0d got=%0h", i, d);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic v1, v2, l;
    logic [15:0] d;
    int xfers;
    int lastbad;
    // Bring the window index to N/2 where the coefficient is 255.
    for (int i = 0; i < N / 2; i++) send_sample(8'sd0, v1, v2, d, l);
    @(posedge clk); #1;
    fft_ready = 1'b0;
    send_sample(-8'sd100, v1, v2, d, l);
    total++;
    if (v2 !== 1'b1 || d !== 16'h009C || l !== 1'b0) begin
      bad++;
      $display("FAIL bp_first got=%0b/%0h/%0b want=1/009c/0", v2, d, l);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      total++;
      if (fft_in_valid !== 1'b1 || fft_in_data !== 16'h009C) begin
        bad++;
        $display("FAIL bp_hold c=%0d got=%0b/%0h want=1/009c", c, fft_in_valid, fft_in_data);
      end
    end
    total++;
    if (overflow_out !== 1'b0) begin
      bad++;
      $display("FAIL bp_no_overflow_yet got=%0b want=0", overflow_out);
    end
    send_sample(8'sd50, v1, v2, d, l);
    total++;
    if (overflow_out !== 1'b1) begin
      bad++;
      $display("FAIL bp_overflow got=%0b want=1", overflow_out);
    end
    total++;
    if (v2 !== 1'b1 || d !== 16'h009C) begin
      bad++;
      $display("FAIL bp_drop_keeps_beat got=%0b/%0h want=1/009c", v2, d);
    end
    fft_ready = 1'b1;
    xfers = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (fft_in_valid && fft_ready) xfers++;
      @(posedge clk);
    end
    #1;
    total++;
    if (xfers !== 1) begin
      bad++;
      $display("FAIL bp_one_transfer got=%0d want=1", xfers);
    end
    total++;
    if (fft_in_valid !== 1'b0 || overflow_out !== 1'b1) begin
      bad++;
      $display("FAIL bp_after got=%0b/%0b want=0/1", fft_in_valid, overflow_out);
    end
    // The dropped sample must not have consumed an index: n is now N/2+1.
    lastbad = 0;
    for (int i = N / 2 + 1; i < N - 1; i++) begin
      send_sample(8'sd0, v1, v2, d, l);
      if (l !== 1'b0) lastbad++;
    end
    total++;
    if (lastbad != 0) begin
      bad++;
      $display("FAIL bp_early_last got=%0d want=0", lastbad);
    end
    send_sample(8'sd0, v1, v2, d, l);
    total++;
    if (l !== 1'b1) begin
      bad++;
      $display("FAIL bp_index_last got=%0b want=1", l);
    end
    send_sample(8'sd0, v1, v2, d, l);
    total++;
    if (l !== 1'b0) begin
      bad++;
      $display("FAIL bp_index_wrap got=%0b want=0", l);
    end
  endtask

  task automatic test_peak();
    clear_frame();
    frame_mem[100] = 16'hE232;           // re 50, im -30
    play_frame(N, 1'b1);
    check_peak("peak_single", 12'd100, 17'd3400);
  endtask

  task automatic test_short_frame();
    clear_frame();
    frame_mem[7] = 16'h0003;             // re 3
    play_frame(50, 1'b1);
    check_peak("peak_short", 12'd7, 17'd9);
  endtask

  task automatic test_exclusion_tie();
    clear_frame();
    frame_mem[0]    = 16'h007F;          // DC, excluded
    frame_mem[200]  = 16'h0028;          // 40
    frame_mem[300]  = 16'h0028;          // tie, later bin
    frame_mem[3000] = 16'h7F7F;          // mirror half, excluded
    play_frame(N, 1'b1);
    check_peak("peak_tie", 12'd200, 17'd1600);
  endtask

  task automatic test_reset_mid_frame();
    clear_frame();
    frame_mem[10] = 16'h0050;            // re 80
    total++;
    if (overflow_out !== 1'b1) begin
      bad++;
      $display("FAIL mid_overflow_sticky got=%0b want=1", overflow_out);
    end
    play_frame(2001, 1'b0);
    rst_in = 1'b0;
    #1;
    total++;
    if (peak_valid_out !== 1'b0 || peak_out !== 12'd0 || peak_mag_out !== 17'd0) begin
      bad++;
      $display("FAIL mid_reset_clear got=%0b/%0d/%0d want=0/0/0", peak_valid_out, peak_out, peak_mag_out);
    end
    total++;
    if (overflow_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_overflow got=%0b want=0", overflow_out);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (peak_valid_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_result got=%0b want=0", peak_valid_out);
    end
    clear_frame();
    frame_mem[500] = 16'h0014;           // re 20
    play_frame(N, 1'b1);
    check_peak("peak_after_reset", 12'd500, 17'd400);
  endtask

  initial begin
    test_reset();
    test_window();
    test_backpressure();
    test_peak();
    test_short_frame();
    test_exclusion_tie();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
